// File: rtl/count_disp_pkg.sv
// Shared constants and types for the count display driver.
package count_disp_pkg;

  // Active-low {g,f,e,d,c,b,a} patterns for the digits 0..9
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam int MAX_COUNT = 19;

  typedef enum logic {UNITS = 1'b0, TENS = 1'b1} phase_t;

endpackage

// File: rtl/count_display_driver_seg7_decode.sv
// 4-bit code to active-low 7-segment pattern: 0..9 digits, 10..14 blank, 15 dash.
module seg7_decode
  import count_disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (code <= 4'd9)       seg = SEG_DIGIT[code];
    else if (code == 4'hF)  seg = SEG_DASH;
  end

endmodule

// File: rtl/count_display_driver.sv
// Two-digit multiplexed common-anode display driver for the 0-19 counter:
// per-frame snapshot, leading-zero blanking, dash on illegal values, blink on pause.
module count_display_driver
  import count_disp_pkg::*;
#(
  parameter int SCAN_DIV   = 1,
  parameter int BLINK_HALF = 50
) (
  input  logic       clk,
  input  logic       reset_clean,
  input  logic [4:0] count,
  input  logic       running,
  output logic [1:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [7:0] SCAN_LAST  = 8'(SCAN_DIV - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_HALF - 1);

  phase_t     phase;
  logic [7:0] scan_cnt;
  logic [7:0] blink_cnt;
  logic       blink_on;
  logic [4:0] snap_count;
  logic       snap_running;

  logic       scan_wrap, frame_start, legal, ge10, hold_blink;
  logic [3:0] units_val, units_code, tens_code, dec_code;
  logic [6:0] dec_seg, seg_next;
  logic [1:0] an_next;
  logic       dp_next;

  assign scan_wrap   = (scan_cnt == SCAN_LAST);
  assign frame_start = scan_wrap && (phase == TENS);
  assign legal       = (snap_count <= 5'(MAX_COUNT));

  // Digit split without a divider: the legal range never exceeds one subtract
  assign ge10       = (snap_count >= 5'd10);
  assign units_val  = ge10 ? 4'(snap_count - 5'd10) : snap_count[3:0];
  assign units_code = legal ? units_val : 4'hF;
  assign tens_code  = !legal ? 4'hF : (ge10 ? 4'd1 : 4'hA);
  assign dec_code   = (phase == UNITS) ? units_code : tens_code;

  seg7_decode u_dec (
    .code (dec_code),
    .seg  (dec_seg)
  );

  // Dashes stay steady, so the blink only gates legal values
  assign seg_next   = (legal && !blink_on) ? SEG_BLANK : dec_seg;
  assign an_next    = (phase == UNITS) ? 2'b10 : 2'b01;
  assign dp_next    = !((phase == UNITS) && !snap_running && legal);
  assign hold_blink = snap_running || !legal;

  always_ff @(posedge clk or posedge reset_clean) begin
    if (reset_clean) begin
      phase        <= UNITS;
      scan_cnt     <= '0;
      blink_cnt    <= '0;
      blink_on     <= 1'b1;
      snap_count   <= '0;
      snap_running <= 1'b1;
      an           <= 2'b11;
      seg          <= SEG_BLANK;
      dp           <= 1'b1;
    end else begin
      if (scan_wrap) begin
        scan_cnt <= '0;
        phase    <= (phase == UNITS) ? TENS : UNITS;
      end else begin
        scan_cnt <= scan_cnt + 8'd1;
      end

      if (frame_start) begin
        snap_count   <= count;
        snap_running <= running;
      end

      // Held at the ON start so every pause opens with a full visible half-period
      if (hold_blink) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= !blink_on;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end

      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_count_display_driver.sv
// Directed self-checking bench for count_display_driver (SCAN_DIV=1, BLINK_HALF=50).
module tb_count_display_driver;

  logic       clk = 1'b0;
  logic       reset_clean;
  logic [4:0] count;
  logic       running;
  logic [1:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_cmp = 0;
  int n_err = 0;

  count_display_driver #(.SCAN_DIV(1), .BLINK_HALF(50)) dut (
    .clk         (clk),
    .reset_clean (reset_clean),
    .count       (count),
    .running     (running),
    .an          (an),
    .seg         (seg),
    .dp          (dp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] ean,
                       input logic [6:0] eseg, input logic edp);
    n_cmp++;
    assert ({an, seg, dp} === {ean, eseg, edp}) else begin
      n_err++;
      $error("FAIL %s: an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
             tag, an, seg, dp, ean, eseg, edp);
    end
  endtask

  // Advance until the pins show the units digit, so the phase register is TENS
  // and the next edge starts a new frame.
  task automatic sync_units();
    bit found = 0;
    for (int k = 0; k < 4 && !found; k++) begin
      tick();
      if (an === 2'b10) found = 1;
    end
    n_cmp++;
    assert (found) else begin
      n_err++;
      $error("FAIL sync_units: an=%b, expected an=10 within 4 cycles", an);
    end
  endtask

  initial begin
    reset_clean = 1'b1;
    count       = 5'd0;
    running     = 1'b1;

    // Reset state, then release and watch the idle 0 display
    #12;
    check("rst_hold", 2'b11, 7'h7F, 1'b1);
    tick();
    check("rst_hold_edge", 2'b11, 7'h7F, 1'b1);
    #3 reset_clean = 1'b0;
    for (int f = 0; f < 3; f++) begin
      tick(); check("idle_units", 2'b10, 7'h40, 1'b1);
      tick(); check("idle_tens",  2'b01, 7'h7F, 1'b1);
    end

    // count=17 running
    sync_units();
    count = 5'd17;
    tick(); check("c17_old_tens", 2'b01, 7'h7F, 1'b1);
    for (int f = 0; f < 2; f++) begin
      tick(); check("c17_units", 2'b10, 7'h78, 1'b1);
      tick(); check("c17_tens",  2'b01, 7'h79, 1'b1);
    end

    // 9 for one frame, then 10 arrives while that frame's tens is pending
    sync_units();
    count = 5'd9;
    tick(); check("c9_old_tens", 2'b01, 7'h79, 1'b1);
    tick(); check("c9_units",    2'b10, 7'h10, 1'b1);
    count = 5'd10;
    tick(); check("c9_tens_no_tear", 2'b01, 7'h7F, 1'b1);
    tick(); check("c10_units",       2'b10, 7'h40, 1'b1);
    tick(); check("c10_tens",        2'b01, 7'h79, 1'b1);

    // Paused at 5: 50 cycles on, 50 off, on again; dp low on every units phase
    sync_units();
    count   = 5'd5;
    running = 1'b0;
    tick(); check("p5_old_tens", 2'b01, 7'h79, 1'b1);
    for (int i = 1; i <= 104; i++) begin
      tick();
      if (i % 2 == 1)
        check("p5_units", 2'b10, (i <= 50 || i > 100) ? 7'h12 : 7'h7F, 1'b0);
      else
        check("p5_tens", 2'b01, 7'h7F, 1'b1);
    end

    // Resume: steady display from the next frame
    sync_units();
    running = 1'b1;
    tick(); check("r5_old_tens", 2'b01, 7'h7F, 1'b1);
    for (int f = 0; f < 2; f++) begin
      tick(); check("r5_units", 2'b10, 7'h12, 1'b1);
      tick(); check("r5_tens",  2'b01, 7'h7F, 1'b1);
    end

    // Illegal 25 while paused: steady dashes, no dp, no blink
    sync_units();
    count   = 5'd25;
    running = 1'b0;
    tick(); check("d25_old_tens", 2'b01, 7'h7F, 1'b1);
    for (int i = 1; i <= 120; i++) begin
      tick();
      if (i % 2 == 1) check("d25_units", 2'b10, 7'h3F, 1'b1);
      else            check("d25_tens",  2'b01, 7'h3F, 1'b1);
    end

    // Back to a running 5, then pause and reset asynchronously in the off half
    sync_units();
    count   = 5'd5;
    running = 1'b1;
    tick(); check("a5_old_tens", 2'b01, 7'h3F, 1'b1);
    tick(); check("a5_units",    2'b10, 7'h12, 1'b1);
    running = 1'b0;
    tick(); check("a5_tens", 2'b01, 7'h7F, 1'b1);
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (i % 2 == 1)
        check("a5_blink_units", 2'b10, (i <= 50) ? 7'h12 : 7'h7F, 1'b0);
      else
        check("a5_blink_tens", 2'b01, 7'h7F, 1'b1);
    end
    #2 reset_clean = 1'b1;
    #1 check("async_rst", 2'b11, 7'h7F, 1'b1);
    count   = 5'd0;
    running = 1'b1;
    tick(); check("async_rst_hold", 2'b11, 7'h7F, 1'b1);
    #3 reset_clean = 1'b0;
    for (int f = 0; f < 2; f++) begin
      tick(); check("restart_units", 2'b10, 7'h40, 1'b1);
      tick(); check("restart_tens",  2'b01, 7'h7F, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
